// File: rtl/sram_pkg.sv
// sram_pkg: shared state encoding, counter width and row-range helper for the SRAM controller
package sram_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PRE,
      ACT,
      RSP
   } state_t;

   localparam int CNT_W = 4;

   function automatic logic row_in_range(input logic [31:0] addr, input int rows);
      return addr < rows;
   endfunction

endpackage

// File: rtl/sram_row_decoder.sv
// sram_row_decoder: binary row address to one-hot wordline, with an out-of-range flag
module sram_row_decoder
   import sram_pkg::*;
#(
   parameter int ROWS   = 16,
   parameter int ADDR_W = 4
) (
   input  logic [ADDR_W-1:0] addr_i,
   input  logic              en_i,
   output logic [ROWS-1:0]   wl_o,
   output logic              in_range_o
);

   // Out-of-range rows match no wordline, so they decode to all-zero.
   always_comb begin
      wl_o       = '0;
      in_range_o = row_in_range(32'(addr_i), ROWS);
      for (int r = 0; r < ROWS; r++) wl_o[r] = en_i && (32'(addr_i) == r);
   end

endmodule

// File: rtl/sram_rw_ctrl.sv
// sram_rw_ctrl: sequences precharge, wordline, write drive and differential sense for one SRAM row access
module sram_rw_ctrl
   import sram_pkg::*;
#(
   parameter int ROWS       = 16,
   parameter int ADDR_W     = 4,
   parameter int WIDTH      = 8,
   parameter int ACT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [WIDTH-1:0]  req_wdata,
   output logic              rsp_valid,
   output logic [WIDTH-1:0]  rsp_rdata,
   output logic              rsp_err,
   output logic              precharge,
   output logic [ROWS-1:0]   wl,
   output logic              bl_drv,
   output logic [WIDTH-1:0]  bl_wdata,
   output logic [WIDTH-1:0]  blb_wdata,
   input  logic [WIDTH-1:0]  bl_sense,
   input  logic [WIDTH-1:0]  blb_sense
);

   state_t             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               we_q;
   logic [ADDR_W-1:0]  addr_q;
   logic [WIDTH-1:0]   wdata_q;
   logic               pre_q;
   logic [ROWS-1:0]    wl_q;
   logic               drv_q;
   logic [WIDTH-1:0]   bl_wdata_q;
   logic [WIDTH-1:0]   blb_wdata_q;
   logic               rsp_valid_q;
   logic [WIDTH-1:0]   rsp_rdata_q;
   logic               rsp_err_q;
   logic [ROWS-1:0]    wl_d;
   logic               in_range;
   logic [WIDTH-1:0]   rdata_d;
   logic               err_d;

   sram_row_decoder #(.ROWS(ROWS), .ADDR_W(ADDR_W)) u_dec (
      .addr_i     (addr_q),
      .en_i       (state_q == PRE),
      .wl_o       (wl_d),
      .in_range_o (in_range)
   );

   // Resolve each bit-pair: only a clean 1/0 or 0/1 differential is valid; equal or unknown rails flag an error.
   always_comb begin
      rdata_d = '0;
      err_d   = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         rdata_d[i] = (bl_sense[i] === 1'b1) && (blb_sense[i] === 1'b0);
         err_d      = err_d | !(rdata_d[i] || ((bl_sense[i] === 1'b0) && (blb_sense[i] === 1'b1)));
      end
   end

   // Access sequencer: IDLE -> PRE -> ACT x ACT_CYCLES -> RSP, all array-side outputs registered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         pre_q       <= 1'b0;
         wl_q        <= '0;
         drv_q       <= 1'b0;
         bl_wdata_q  <= '0;
         blb_wdata_q <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (req_valid) begin
               we_q    <= req_we;
               addr_q  <= req_addr;
               wdata_q <= req_wdata;
               pre_q   <= 1'b1;
               state_q <= PRE;
            end
            PRE: begin
               pre_q       <= 1'b0;
               wl_q        <= wl_d;
               drv_q       <= we_q && in_range;
               bl_wdata_q  <= we_q && in_range ? wdata_q : '0;
               blb_wdata_q <= we_q && in_range ? ~wdata_q : '0;
               cnt_q       <= CNT_W'(ACT_CYCLES - 1);
               state_q     <= ACT;
            end
            ACT: if (cnt_q == '0) begin
               wl_q        <= '0;
               drv_q       <= 1'b0;
               bl_wdata_q  <= '0;
               blb_wdata_q <= '0;
               rsp_valid_q <= 1'b1;
               rsp_rdata_q <= we_q || !in_range ? '0 : rdata_d;
               rsp_err_q   <= !in_range || (!we_q && err_d);
               state_q     <= RSP;
            end else begin
               cnt_q <= cnt_q - 1'b1;
            end
            RSP: begin
               rsp_valid_q <= 1'b0;
               state_q     <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_ready = (state_q == IDLE) && !rst;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign precharge = pre_q;
   assign wl        = wl_q;
   assign bl_drv    = drv_q;
   assign bl_wdata  = bl_wdata_q;
   assign blb_wdata = blb_wdata_q;

endmodule

// File: tb/tb_sram_rw_ctrl.sv
// tb_sram_rw_ctrl: vector table, random traffic against an array reference model, and multi-cycle corner sequences
module tb_sram_rw_ctrl;

   localparam int ROWS = 16;
   localparam int AW   = 5;
   localparam int W    = 8;
   localparam int ACT  = 2;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            req_valid = 1'b0;
   logic            req_ready;
   logic            req_we = 1'b0;
   logic [AW-1:0]   req_addr = '0;
   logic [W-1:0]    req_wdata = '0;
   logic            rsp_valid;
   logic [W-1:0]    rsp_rdata;
   logic            rsp_err;
   logic            precharge;
   logic [ROWS-1:0] wl;
   logic            bl_drv;
   logic [W-1:0]    bl_wdata;
   logic [W-1:0]    blb_wdata;
   logic [W-1:0]    bl_sense;
   logic [W-1:0]    blb_sense;

   logic            force_en = 1'b0;
   logic [W-1:0]    fbl = '0;
   logic [W-1:0]    fblb = '0;

   logic [W-1:0]    cells [ROWS];
   logic [ROWS-1:0] cell_ok = '0;
   logic [W-1:0]    ref_mem [ROWS];
   logic [ROWS-1:0] ref_ok = '0;

   int n_cmp = 0;
   int n_bad = 0;

   sram_rw_ctrl #(.ROWS(ROWS), .ADDR_W(AW), .WIDTH(W), .ACT_CYCLES(ACT)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .precharge (precharge),
      .wl        (wl),
      .bl_drv    (bl_drv),
      .bl_wdata  (bl_wdata),
      .blb_wdata (blb_wdata),
      .bl_sense  (bl_sense),
      .blb_sense (blb_sense)
   );

   always #5 clk = ~clk;

   // Array of 6T cells: written through the driven bitlines, read back as a differential pair.
   always @(posedge clk)
      for (int r = 0; r < ROWS; r++)
         if (bl_drv && wl[r]) begin
            cells[r]   <= bl_wdata;
            cell_ok[r] <= (bl_wdata == ~blb_wdata);
         end

   // Selected row drives the sense rails; a never-written cell leaves both rails high.
   always_comb begin
      bl_sense  = '1;
      blb_sense = '1;
      for (int r = 0; r < ROWS; r++)
         if (wl[r] && !bl_drv && cell_ok[r]) begin
            bl_sense  = cells[r];
            blb_sense = ~cells[r];
         end
      if (force_en) begin
         bl_sense  = fbl;
         blb_sense = fblb;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Array-level invariants, every cycle outside reset.
   always @(negedge clk)
      if (!rst) begin
         chk("inv_onehot", 32'($countones(wl) <= 1), 1);
         chk("inv_pre_wl", 32'(precharge && (wl != 0)), 0);
         chk("inv_drv_wl", 32'(bl_drv && (wl == 0)), 0);
      end

   task automatic model(input logic we, input logic [AW-1:0] addr, input logic [W-1:0] wd,
                        input logic fe, input logic [W-1:0] fb, input logic [W-1:0] fbb,
                        output logic [W-1:0] erd, output logic ee);
      erd = '0;
      ee  = 1'b0;
      if (addr >= ROWS) ee = 1'b1;
      else if (we) begin
         ref_mem[addr[3:0]] = wd;
         ref_ok[addr[3:0]]  = 1'b1;
      end else if (fe) begin
         for (int i = 0; i < W; i++) begin
            erd[i] = fb[i] & ~fbb[i];
            if (fb[i] == fbb[i]) ee = 1'b1;
         end
      end else if (ref_ok[addr[3:0]]) erd = ref_mem[addr[3:0]];
      else ee = 1'b1;
   endtask

   task automatic do_access(input logic we, input logic [AW-1:0] addr, input logic [W-1:0] wd,
                            input logic fe, input logic [W-1:0] fb, input logic [W-1:0] fbb);
      logic [W-1:0]    erd;
      logic            ee;
      logic            inr;
      logic [ROWS-1:0] ewl;
      int k;
      model(we, addr, wd, fe, fb, fbb, erd, ee);
      inr = addr < ROWS;
      ewl = inr ? ROWS'(1) << addr : '0;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
      force_en = fe; fbl = fb; fblb = fbb;
      k = 0;
      while (!req_ready && k < 20) begin @(negedge clk); k++; end
      chk("ready", 32'(req_ready), 1);
      @(posedge clk);
      for (int c = 1; c <= 3 + ACT; c++) begin
         @(negedge clk);
         if (c == 1) begin
            req_valid = 1'b0; req_we = 1'($urandom); req_addr = AW'($urandom); req_wdata = W'($urandom);
            chk("pre", {precharge, wl, bl_drv, rsp_valid, req_ready}, {1'b1, 16'h0, 1'b0, 1'b0, 1'b0});
         end else if (c <= 1 + ACT) begin
            chk("act", {precharge, wl, bl_drv, rsp_valid}, {1'b0, ewl, we && inr, 1'b0});
            if (we && inr) chk("act_bl", {bl_wdata, blb_wdata}, {wd, ~wd});
         end else if (c == 2 + ACT) begin
            chk("rsp", {rsp_valid, rsp_rdata, rsp_err, wl, bl_drv}, {1'b1, erd, ee, 16'h0, 1'b0});
         end else begin
            chk("hold", {rsp_valid, rsp_rdata, rsp_err, req_ready}, {1'b0, erd, ee, 1'b1});
         end
      end
      force_en = 1'b0;
   endtask

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [W-1:0]  wd;
      logic          fe;
      logic [W-1:0]  fb;
      logic [W-1:0]  fbb;
      logic [W-1:0]  erd;
      logic          ee;
   } vec_t;

   vec_t vecs [12];

   initial begin
      int hs_t [3];
      int n_hs;
      int k;
      logic [W-1:0] erd;
      logic ee;
      vecs[0]  = '{1'b1, 5'd3,  8'hA5, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0};
      vecs[1]  = '{1'b0, 5'd3,  8'h00, 1'b0, 8'h00, 8'h00, 8'hA5, 1'b0};
      vecs[2]  = '{1'b0, 5'd5,  8'h00, 1'b1, 8'hFF, 8'hFF, 8'h00, 1'b1};
      vecs[3]  = '{1'b0, 5'd20, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1};
      vecs[4]  = '{1'b1, 5'd20, 8'h5C, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1};
      vecs[5]  = '{1'b0, 5'd7,  8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1};
      vecs[6]  = '{1'b1, 5'd7,  8'h3C, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0};
      vecs[7]  = '{1'b0, 5'd7,  8'h00, 1'b0, 8'h00, 8'h00, 8'h3C, 1'b0};
      vecs[8]  = '{1'b1, 5'd15, 8'hFF, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0};
      vecs[9]  = '{1'b0, 5'd15, 8'h00, 1'b0, 8'h00, 8'h00, 8'hFF, 1'b0};
      vecs[10] = '{1'b1, 5'd0,  8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0};
      vecs[11] = '{1'b0, 5'd6,  8'h00, 1'b1, 8'hF0, 8'h0F, 8'hF0, 1'b0};

      repeat (3) @(negedge clk);
      chk("rst_outs", {req_ready, rsp_valid, rsp_rdata, rsp_err, precharge, wl, bl_drv, bl_wdata, blb_wdata},
          {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0, 1'b0, 8'h00, 8'h00});
      rst = 1'b0;
      #1 chk("rst_ready", 32'(req_ready), 1);

      // Directed vector table: expected response fields are fixed in the table.
      for (int v = 0; v < 12; v++) begin
         model(vecs[v].we, vecs[v].addr, vecs[v].wd, vecs[v].fe, vecs[v].fb, vecs[v].fbb, erd, ee);
         chk("vec_model", {erd, ee}, {vecs[v].erd, vecs[v].ee});
         ref_ok[vecs[v].addr[3:0]] = vecs[v].addr < ROWS && vecs[v].we ? 1'b0 : ref_ok[vecs[v].addr[3:0]];
         do_access(vecs[v].we, vecs[v].addr, vecs[v].wd, vecs[v].fe, vecs[v].fb, vecs[v].fbb);
      end

      // Back-to-back writes with req_valid held high.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 5'd9; req_wdata = 8'h11;
      n_hs = 0;
      for (int c = 0; c < 40 && n_hs < 3; c++) begin
         if (req_ready) begin
            hs_t[n_hs] = c;
            chk("b2b_wl_gap", 32'(wl), 0);
            model(1'b1, req_addr, req_wdata, 1'b0, 8'h0, 8'h0, erd, ee);
            n_hs++;
            @(negedge clk);
            req_addr  = req_addr + 1'b1;
            req_wdata = req_wdata + 8'h11;
            if (n_hs == 3) req_valid = 1'b0;
         end else @(negedge clk);
      end
      chk("b2b_count", n_hs, 3);
      chk("b2b_gap1", hs_t[1] - hs_t[0], 3 + ACT);
      chk("b2b_gap2", hs_t[2] - hs_t[1], 3 + ACT);
      k = 0;
      while (!req_ready && k < 20) begin @(negedge clk); k++; end
      for (int a = 9; a <= 11; a++) do_access(1'b0, AW'(a), 8'h00, 1'b0, 8'h0, 8'h0);

      // Random traffic against the reference model.
      for (int n = 0; n < 60; n++) begin
         logic we;
         logic fe;
         we = 1'($urandom);
         fe = !we && ($urandom_range(0, 3) == 0);
         do_access(we, AW'($urandom_range(0, 20)), W'($urandom), fe, W'($urandom), W'($urandom));
      end

      // Reset in the middle of a write's ACT phase.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 5'd12; req_wdata = 8'h77;
      k = 0;
      while (!req_ready && k < 20) begin @(negedge clk); k++; end
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      chk("rst_mid_act", {wl, bl_drv}, {16'h1000, 1'b1});
      #1 rst = 1'b1;
      #1 chk("rst_mid_outs", {wl, bl_drv, precharge, req_ready}, {16'h0, 1'b0, 1'b0, 1'b0});
      @(negedge clk);
      rst = 1'b0;
      #1 chk("rst_mid_ready", 32'(req_ready), 1);
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         chk("rst_no_rsp", {rsp_valid, wl, precharge}, {1'b0, 16'h0, 1'b0});
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule

// File: doc/sram_rw_ctrl.md
Name: sram_rw_ctrl

Overview:
- Array-side controller for the 6T SRAM cell: the initiator/driver end of the cell's wordline/bitline interface.
- Accepts single-word read/write requests from a valid/ready front end.
- Sequences precharge, wordline assertion, bitline drive (write) and differential sense/capture (read) for one row of WIDTH cells.
- Returns a one-cycle response pulse with read data and an error flag.

Parameters:
- ROWS, 16, number of wordlines (rows) in the array.
- ADDR_W, 4, request address width; must satisfy 2**ADDR_W >= ROWS.
- WIDTH, 8, cells per row (bit-pairs per word).
- ACT_CYCLES, 2, cycles the wordline stays asserted per access; legal range 1..15.

Ports:
- clk  in  1  single clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request (IDLE only).
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  row index.
- req_wdata  in  WIDTH  write data.
- rsp_valid  out  1  one-cycle completion pulse (read or write).
- rsp_rdata  out  WIDTH  read data (0 for writes).
- rsp_err  out  1  error flag, valid with rsp_valid.
- precharge  out  1  bitline precharge enable.
- wl  out  ROWS  one-hot wordlines.
- bl_drv  out  1  write drivers enabled; bitlines carry bl_wdata/blb_wdata.
- bl_wdata  out  WIDTH  true-rail write value.
- blb_wdata  out  WIDTH  complement-rail write value.
- bl_sense  in  WIDTH  true-rail bitline sense input.
- blb_sense  in  WIDTH  complement-rail bitline sense input.

Behaviour:
- Reset (asynchronous, immediate, including mid-access):
  - req_ready=0 while rst=1.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, precharge=0, wl=0, bl_drv=0, bl_wdata=0, blb_wdata=0.
  - State returns to IDLE; the in-flight request is dropped with no response.
  - req_ready=1 the first cycle after rst deasserts.
- State machine and timing (cycle 0 is the handshake edge):
  - IDLE: req_ready=1. A handshake (req_valid && req_ready) latches we/addr/wdata and moves to PRE.
  - PRE (1 cycle, cycle 1): precharge=1; wl=0 and bl_drv=0 throughout.
  - ACT (ACT_CYCLES cycles, cycles 2..1+ACT_CYCLES): precharge=0; wl[addr]=1, all other wl bits 0.
    - Write: bl_drv=1, bl_wdata=wdata, blb_wdata=~wdata for the whole of ACT.
    - Read: bl_drv=0. On the last ACT cycle, bl_sense/blb_sense are sampled into rdata/err registers.
  - RSP (1 cycle, cycle 2+ACT_CYCLES): wl=0, bl_drv=0, rsp_valid=1 with rdata/err. Next state is IDLE.
- Back-to-back throughput: one access per 3+ACT_CYCLES cycles. req_ready returns high the cycle after RSP.
- Response path:
  - rsp_rdata and rsp_err hold their value until the next RSP.
  - There is no response backpressure.
- Read sensing, per column i:
  - bl_sense=1, blb_sense=0 gives rdata[i]=1.
  - bl_sense=0, blb_sense=1 gives rdata[i]=0.
  - Equal rails, or any X/Z on either rail (undriven cell), gives rdata[i]=0 and sets rsp_err=1.
- Address range: if addr >= ROWS, the PRE/ACT/RSP timing is unchanged, but no wl bit asserts, bl_drv stays 0, rsp_rdata=0 and rsp_err=1.
- Writes: rsp_err=0 unless the address is out of range; rsp_rdata=0.
- Invariants, all required to hold in every cycle:
  - wl is one-hot or zero.
  - precharge and any wl bit are never high together.
  - bl_drv is never high without a wl bit.
  - There is at least one all-zero wl cycle between consecutive accesses.
- req_we/req_addr/req_wdata are ignored outside the handshake cycle.

Decomposition:
- Shared package sram_pkg:
  - state enum (IDLE, PRE, ACT, RSP);
  - ACT counter width constant (4 bits);
  - row-range check function.
- One sub-module, sram_row_decoder: binary addr plus enable in, one-hot wl out, in_range flag out; purely combinational, and its output is registered in the controller.

Test Plan:
- Reset then write addr=3, wdata=0xA5 with ACT_CYCLES=2:
  - precharge=1 at cycle 1;
  - wl=0x0008, bl_drv=1, bl_wdata=0xA5, blb_wdata=0x5A at cycles 2-3;
  - rsp_valid=1, rsp_err=0 at cycle 4.
- Read addr=3 after that write, using an array model of SRAMcell instances:
  - wl=0x0008 at cycles 2-3;
  - rsp_valid at cycle 4 with rsp_rdata=0xA5, rsp_err=0.
- Read addr=5 with bl_sense=blb_sense=0xFF (no valid differential) -> rsp_rdata=0x00, rsp_err=1.
- Read addr=20 with ROWS=16, ADDR_W=5:
  - wl stays 0 for the whole access;
  - rsp_valid at cycle 4 with rsp_err=1, rsp_rdata=0.
- Hold req_valid high for 3 back-to-back writes -> handshakes exactly 5 cycles apart, with wl=0 for at least one cycle between accesses.
- Assert rst during ACT of a write:
  - wl, bl_drv and precharge fall to 0 in the same cycle;
  - no rsp_valid follows;
  - req_ready=1 the first cycle after rst deasserts.
